// File: rtl/traffic_pkg.sv
// Shared types and helpers for the N-way traffic phase controller.
// State encodings, per-approach lamp encoding and counter width sizing.
package traffic_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_ALL_RED = 2'd0;
  localparam state_t ST_GREEN   = 2'd1;
  localparam state_t ST_YELLOW  = 2'd2;
  localparam state_t ST_FLASH   = 2'd3;

  // Width able to hold the largest terminal count (ticks-1) without wrapping.
  function automatic int cnt_width(input int g, input int y, input int r);
    int m;
    m = g;
    if (y > m) m = y;
    if (r > m) m = r;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

  // Lamp triple {red, yellow, green} for one approach; sel marks the owning approach.
  function automatic logic [2:0] lamp_encode(input state_t st, input logic sel,
                                             input logic flash_on);
    logic [2:0] l;
    l = 3'b100;
    case (st)
      ST_GREEN:  l = sel ? 3'b001 : 3'b100;
      ST_YELLOW: l = sel ? 3'b010 : 3'b100;
      ST_FLASH:  l = flash_on ? 3'b010 : 3'b000;
      default:   l = 3'b100;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_tick_counter.sv
// Tick-gated phase counter: clears on phase change, flags the terminal value.
module traffic_tick_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic [CW-1:0] term,
  output logic [CW-1:0] cnt,
  output logic          hit
);

  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en)    cnt <= cnt + 1'b1;
  end

  assign hit = (cnt == term);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// N-way intersection light controller with all-red clearance and pedestrian early-exit.
// Optional night flashing mode is built in when NIGHT_FLASH_EN is defined.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int N_WAYS          = 2,
  parameter int GREEN_TICKS     = 10,
  parameter int MIN_GREEN_TICKS = 3,
  parameter int YELLOW_TICKS    = 1,
  parameter int ALLRED_TICKS    = 1,
  parameter int START_WAY       = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick,
  input  logic                      ped_req,
`ifdef NIGHT_FLASH_EN
  input  logic                      night_mode,
`endif
  output logic [N_WAYS-1:0]         red,
  output logic [N_WAYS-1:0]         yellow,
  output logic [N_WAYS-1:0]         green,
  output logic [$clog2(N_WAYS)-1:0] active_way,
  output logic                      phase_start
);

  localparam int CW = cnt_width(GREEN_TICKS, YELLOW_TICKS, ALLRED_TICKS);
  localparam int WW = $clog2(N_WAYS);

  if (N_WAYS < 2 || N_WAYS > 8) begin : g_chk_ways
    $error("N_WAYS must be in 2..8");
  end
  if (MIN_GREEN_TICKS < 1 || MIN_GREEN_TICKS > GREEN_TICKS) begin : g_chk_min
    $error("MIN_GREEN_TICKS must be in 1..GREEN_TICKS");
  end
  if (YELLOW_TICKS < 1 || ALLRED_TICKS < 1) begin : g_chk_len
    $error("YELLOW_TICKS and ALLRED_TICKS must be >= 1");
  end
  if (START_WAY < 0 || START_WAY >= N_WAYS) begin : g_chk_start
    $error("START_WAY must be < N_WAYS");
  end

  state_t          state, nxt_state;
  logic [WW-1:0]   way, nxt_way;
  logic [CW-1:0]   cnt, term;
  logic            hit, changed, ped_pending, flash_bit;

`ifdef NIGHT_FLASH_EN
  logic flash_on, nxt_flash;
`endif

  traffic_tick_counter #(.CW(CW)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (tick && (state != ST_FLASH)),
    .clr  (changed),
    .term (term),
    .cnt  (cnt),
    .hit  (hit)
  );

  always_comb begin
    nxt_state = state;
    nxt_way   = way;
    term      = '0;
`ifdef NIGHT_FLASH_EN
    nxt_flash = flash_on;
`endif
    case (state)
      ST_ALL_RED: begin
        term = CW'(ALLRED_TICKS - 1);
        if (tick && hit) begin
          nxt_state = ST_GREEN;
`ifdef NIGHT_FLASH_EN
          if (night_mode) begin
            nxt_state = ST_FLASH;
            nxt_flash = 1'b1;
          end
`endif
        end
      end
      ST_GREEN: begin
        term = CW'(GREEN_TICKS - 1);
        // A latched ped request only shortens green once the minimum has elapsed.
        if (tick && (hit || (ped_pending && cnt >= CW'(MIN_GREEN_TICKS - 1))))
          nxt_state = ST_YELLOW;
      end
      ST_YELLOW: begin
        term = CW'(YELLOW_TICKS - 1);
        if (tick && hit) begin
          nxt_state = ST_ALL_RED;
          nxt_way   = (way == WW'(N_WAYS - 1)) ? '0 : way + 1'b1;
        end
      end
`ifdef NIGHT_FLASH_EN
      ST_FLASH: begin
        if (tick) begin
          if (!night_mode) nxt_state = ST_ALL_RED;
          else             nxt_flash = ~flash_on;
        end
      end
`endif
      default: nxt_state = ST_ALL_RED;
    endcase
  end

  assign changed = (nxt_state != state);

`ifdef NIGHT_FLASH_EN
  assign flash_bit = nxt_flash;
  always_ff @(posedge clk) begin
    if (rst) flash_on <= 1'b0;
    else     flash_on <= nxt_flash;
  end
`else
  assign flash_bit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_ALL_RED;
      way         <= WW'(START_WAY);
      phase_start <= 1'b0;
    end else begin
      state       <= nxt_state;
      way         <= nxt_way;
      phase_start <= changed;
    end
  end

  // Clear on GREEN->YELLOW wins over a request arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst)                                            ped_pending <= 1'b0;
    else if (state == ST_GREEN && nxt_state == ST_YELLOW) ped_pending <= 1'b0;
    else if (ped_req)                                   ped_pending <= 1'b1;
  end

  logic [2:0] enc [N_WAYS];
  for (genvar i = 0; i < N_WAYS; i++) begin : g_lamp
    assign enc[i] = lamp_encode(nxt_state, nxt_way == WW'(i), flash_bit);
  end

  // Lamps are registered from next-state so they change on the same edge as state.
  always_ff @(posedge clk) begin
    if (rst) begin
      red    <= '1;
      yellow <= '0;
      green  <= '0;
    end else begin
      for (int i = 0; i < N_WAYS; i++) {red[i], yellow[i], green[i]} <= enc[i];
    end
  end

  assign active_way = way;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl (N_WAYS=3, other parameters default).
module tb_traffic_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst, tick, ped_req;
  logic [2:0] red, yellow, green;
  logic [1:0] active_way;
  logic       phase_start;
`ifdef NIGHT_FLASH_EN
  logic       night_mode;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  traffic_phase_ctrl #(.N_WAYS(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .ped_req     (ped_req),
`ifdef NIGHT_FLASH_EN
    .night_mode  (night_mode),
`endif
    .red         (red),
    .yellow      (yellow),
    .green       (green),
    .active_way  (active_way),
    .phase_start (phase_start)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic lamps(input string tag, input logic [2:0] r, input logic [2:0] y,
                       input logic [2:0] g, input logic [1:0] aw);
    chk({tag, ".red"},    8'(red),        8'(r));
    chk({tag, ".yellow"}, 8'(yellow),     8'(y));
    chk({tag, ".green"},  8'(green),      8'(g));
    chk({tag, ".way"},    8'(active_way), 8'(aw));
  endtask

  // Each tick is preceded by one idle cycle; returns at the negedge after the tick edge.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; ped_req = 1'b0;
`ifdef NIGHT_FLASH_EN
    night_mode = 1'b0;
`endif
    repeat (3) @(negedge clk);
    lamps("reset", 3'b111, 3'b000, 3'b000, 2'd0);
    chk("reset.ps", 8'(phase_start), 8'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    lamps("no_tick", 3'b111, 3'b000, 3'b000, 2'd0);

    // Rotation through all three approaches with full-length greens
    ticks(1);  lamps("g0", 3'b110, 3'b000, 3'b001, 2'd0);
    chk("g0.ps", 8'(phase_start), 8'd1);
    @(negedge clk); chk("g0.ps_drop", 8'(phase_start), 8'd0);
    ticks(9);  lamps("g0_hold", 3'b110, 3'b000, 3'b001, 2'd0);
    ticks(1);  lamps("y0", 3'b110, 3'b001, 3'b000, 2'd0);
    chk("y0.ps", 8'(phase_start), 8'd1);
    ticks(1);  lamps("r0", 3'b111, 3'b000, 3'b000, 2'd1);
    ticks(1);  lamps("g1", 3'b101, 3'b000, 3'b010, 2'd1);
    ticks(10); lamps("y1", 3'b101, 3'b010, 3'b000, 2'd1);
    ticks(1);  lamps("r1", 3'b111, 3'b000, 3'b000, 2'd2);
    ticks(1);  lamps("g2", 3'b011, 3'b000, 3'b100, 2'd2);
    ticks(10); lamps("y2", 3'b011, 3'b100, 3'b000, 2'd2);
    ticks(1);  lamps("wrap", 3'b111, 3'b000, 3'b000, 2'd0);
    ticks(1);  lamps("g0b", 3'b110, 3'b000, 3'b001, 2'd0);

    // Ped pulse after first green tick: green ends on the third tick
    ticks(1);
    ped_req = 1'b1; @(negedge clk); ped_req = 1'b0;
    ticks(1);  lamps("ped_g", 3'b110, 3'b000, 3'b001, 2'd0);
    ticks(1);  lamps("ped_y", 3'b110, 3'b001, 3'b000, 2'd0);
    ticks(1);  lamps("ped_r", 3'b111, 3'b000, 3'b000, 2'd1);
    ticks(1);  lamps("clr_g1", 3'b101, 3'b000, 3'b010, 2'd1);
    ticks(3);  lamps("clr_hold", 3'b101, 3'b000, 3'b010, 2'd1);
    ticks(7);  lamps("clr_y1", 3'b101, 3'b010, 3'b000, 2'd1);

    // Ped during yellow carries over: next green lasts MIN_GREEN_TICKS
    ped_req = 1'b1; @(negedge clk); ped_req = 1'b0;
    ticks(1);  lamps("carry_r", 3'b111, 3'b000, 3'b000, 2'd2);
    ticks(1);  lamps("carry_g", 3'b011, 3'b000, 3'b100, 2'd2);
    ticks(2);  lamps("carry_hold", 3'b011, 3'b000, 3'b100, 2'd2);
    ticks(1);  lamps("carry_y", 3'b011, 3'b100, 3'b000, 2'd2);

    // ped_req high through the exit cycle: clear wins, next green is full length
    ticks(1);  lamps("sc_r", 3'b111, 3'b000, 3'b000, 2'd0);
    ticks(1);  lamps("sc_g0", 3'b110, 3'b000, 3'b001, 2'd0);
    ped_req = 1'b1;
    ticks(3);
    ped_req = 1'b0;
    lamps("sc_y0", 3'b110, 3'b001, 3'b000, 2'd0);
    ticks(1);  lamps("sc_r1", 3'b111, 3'b000, 3'b000, 2'd1);
    ticks(1);  lamps("sc_g1", 3'b101, 3'b000, 3'b010, 2'd1);
    ticks(3);  lamps("sc_hold", 3'b101, 3'b000, 3'b010, 2'd1);

    // Reset together with tick mid-green
    @(negedge clk);
    rst = 1'b1; tick = 1'b1;
    @(negedge clk);
    rst = 1'b0; tick = 1'b0;
    lamps("rst_mid", 3'b111, 3'b000, 3'b000, 2'd0);
    chk("rst_mid.ps", 8'(phase_start), 8'd0);
    ticks(1);  lamps("rst_g0", 3'b110, 3'b000, 3'b001, 2'd0);
    chk("rst_g0.ps", 8'(phase_start), 8'd1);

`ifdef NIGHT_FLASH_EN
    night_mode = 1'b1;
    ticks(10); lamps("n_y0", 3'b110, 3'b001, 3'b000, 2'd0);
    ticks(1);  lamps("n_r", 3'b111, 3'b000, 3'b000, 2'd1);
    ticks(1);  lamps("flash_on", 3'b000, 3'b111, 3'b000, 2'd1);
    ticks(1);  lamps("flash_off", 3'b000, 3'b000, 3'b000, 2'd1);
    ticks(1);  lamps("flash_on2", 3'b000, 3'b111, 3'b000, 2'd1);
    night_mode = 1'b0;
    ticks(1);  lamps("flash_exit", 3'b111, 3'b000, 3'b000, 2'd1);
    ticks(1);  lamps("flash_g1", 3'b101, 3'b000, 3'b010, 2'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
